// File: rtl/pipe_stage_skid_if.sv
// Valid/ready pipeline channel carrying payload words, write-register address and control bits.
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DATA_N = 3,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CTRL_W = 2
);
   localparam int unsigned PAY_W = DATA_W * DATA_N;

   logic              valid;
   logic              ready;
   logic [PAY_W-1:0]  data;
   logic [ADDR_W-1:0] addr;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output addr, output ctrl, input ready);
   modport slave  (input valid, input data, input addr, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush, saturating stall counter and
// an optional 2-entry skid buffer that breaks the out_ready -> in_ready combinational path.
module pipe_stage_skid #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DATA_N  = 3,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned CTRL_W  = 2,
   parameter int unsigned SKID    = 1,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   pipe_stage_skid_if.slave   up,
   pipe_stage_skid_if.master  dn,
   output logic [STALL_W-1:0] stall_cnt
);
   localparam int unsigned PAY_W = DATA_W * DATA_N;

   typedef struct packed {
      logic [PAY_W-1:0]  data;
      logic [ADDR_W-1:0] addr;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   entry_t             main_q, main_d;
   entry_t             skid_q, skid_d;
   entry_t             in_entry;
   logic [STALL_W-1:0] stall_q;
   logic               in_ready_c;
   logic               out_valid_c;
   logic               in_xfer_c;
   logic               out_xfer_c;

   assign in_entry    = '{data: up.data, addr: up.addr, ctrl: up.ctrl};
   assign out_valid_c = (state_q != EMPTY);

   // Skid mode decodes in_ready from state only; register mode passes out_ready through.
   if (SKID != 0) begin : g_skid_ready
      assign in_ready_c = ~reset & (state_q != FULL);
   end else begin : g_reg_ready
      assign in_ready_c = ~reset & (~out_valid_c | dn.ready);
   end

   assign in_xfer_c  = up.valid & in_ready_c;
   assign out_xfer_c = out_valid_c & dn.ready;

   // Next-state and entry steering; ctrl is cleared whenever the stage goes empty.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d     = EMPTY;
         main_d.ctrl = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer_c) begin
                  main_d  = in_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_xfer_c && out_xfer_c) begin
                  main_d = in_entry;
               end else if ((SKID != 0) && in_xfer_c) begin
                  skid_d  = in_entry;
                  state_d = FULL;
               end else if (out_xfer_c) begin
                  main_d.ctrl = '0;
                  state_d     = EMPTY;
               end
            end
            FULL: begin
               if (out_xfer_c) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: begin
               state_d     = EMPTY;
               main_d.ctrl = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Counts cycles the head is offered but not taken; holds at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid_c && !dn.ready && (stall_q != {STALL_W{1'b1}})) begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end

   assign up.ready  = in_ready_c;
   assign dn.valid  = out_valid_c;
   assign dn.data   = main_q.data;
   assign dn.addr   = main_q.addr;
   assign dn.ctrl   = main_q.ctrl;
   assign stall_cnt = stall_q;
endmodule
